// File: rtl/riscv_pkg.sv
// Shared encodings for the load/store unit: funct3 size codes, FSM states
// and byte-strobe constants.
package riscv_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } lsu_state_e;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

    function automatic logic [3:0] store_strobe(input logic [2:0] funct3,
                                                input logic [1:0] offset);
        logic [3:0] strb;
        strb = STRB_NONE;
        case (funct3)
            F3_B:    strb = STRB_B << offset;
            F3_H:    strb = STRB_H << offset;
            F3_W:    strb = STRB_W;
            default: strb = STRB_NONE;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword lane out of a little-endian memory word
// and sign- or zero-extends it according to funct3.
module load_align
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            offset_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata_i[7:0];
        case (offset_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_B:    data_o = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            F3_BU:   data_o = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
            F3_H:    data_o = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            F3_HU:   data_o = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: registers a core request, performs one
// word access on the memory port (with timeout) and returns a one-cycle response.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_valid,
    output logic [3:0]            mem_wstrb,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    lsu_state_e            state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  ready_en_q;

    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            offset_q, offset_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  fault;
    logic [DATA_WIDTH-1:0] load_data;

    assign accept = req_valid && req_ready;

    always_comb begin
        fault = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: fault = 1'b0;
            F3_H, F3_HU: fault = req_addr[0];
            F3_W:        fault = (req_addr[1:0] != 2'b00);
            default:     fault = 1'b1;
        endcase
        if (req_we && req_funct3[2]) begin
            fault = 1'b1;
        end
        if ((req_addr >> (ADDR_WIDTH + 2)) != '0) begin
            fault = 1'b1;
        end
    end

    // State register; ready_en_q holds req_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = fault ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ready || (wait_q == WAIT_LAST)) begin
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        resp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE:   req_ready  = ready_en_q;
            ST_ACCESS: mem_valid  = 1'b1;
            ST_RESP:   resp_valid = 1'b1;
            default:   req_ready  = 1'b0;
        endcase
    end

    load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .funct3_i(funct3_q),
        .offset_i(offset_q),
        .rdata_i (mem_rdata),
        .data_o  (load_data)
    );

    always_comb begin
        funct3_d = funct3_q;
        offset_d = offset_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (accept) begin
            funct3_d = req_funct3;
            offset_d = req_addr[1:0];
            we_d     = req_we;
            addr_d   = req_addr[ADDR_WIDTH+1:2];
            wstrb_d  = req_we ? store_strobe(req_funct3, req_addr[1:0]) : STRB_NONE;
            case (req_funct3)
                F3_B:    wdata_d = {(DATA_WIDTH/8){req_wdata[7:0]}};
                F3_H:    wdata_d = {(DATA_WIDTH/16){req_wdata[15:0]}};
                default: wdata_d = req_wdata;
            endcase
            rdata_d = '0;
            err_d   = fault;
        end else if (state_q == ST_ACCESS) begin
            if (mem_ready) begin
                rdata_d = we_q ? '0 : load_data;
            end else if (wait_q == WAIT_LAST) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q <= '0;
            offset_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            funct3_q <= funct3_d;
            offset_q <= offset_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_wdata  = wdata_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-level memory model.
module tb_load_store_unit;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = '0;
    logic [31:0]   req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          mem_valid;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    load_store_unit #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_valid (mem_valid),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          mv;
    } exp_t;

    typedef struct {
        logic [19:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          is_store;
    } mexp_t;

    typedef struct {
        int w;
        bit stall;
    } cfg_t;

    exp_t        exp_q[$];
    mexp_t       mem_q[$];
    cfg_t        cfg_q[$];
    logic [31:0] tb_mem [256];
    logic [31:0] ref_mem[256];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int mv_cnt = 0;
    bit busy = 0;
    int cur_w = 0;
    bit cur_stall = 0;
    int wait_cnt = 0;

    assign mem_ready = mem_valid && !cur_stall && (wait_cnt >= cur_w);
    assign mem_rdata = tb_mem[mem_addr[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n || !mem_valid || mem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // Monitor: memory-side and response-side scoreboards, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t  e;
        mexp_t m;
        cfg_t  c;
        if (!rst_n) begin
            busy = 0;
        end else begin
            if (mem_valid) mv_cnt++;
            if (busy) check("req_ready_while_busy", {31'b0, req_ready}, 32'd0);
            if (mem_valid && mem_ready) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected: handshake at addr 0x%05h with none expected", mem_addr);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_addr", {12'b0, mem_addr}, {12'b0, m.addr});
                    check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, m.wstrb});
                    if (m.is_store) check("mem_wdata", mem_wdata, m.wdata);
                    for (int i = 0; i < 4; i++)
                        if (mem_wstrb[i]) tb_mem[mem_addr[7:0]][8*i +: 8] = mem_wdata[8*i +: 8];
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: resp_valid with none expected, rdata 0x%08h", resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    check("resp_latency", cyc - acc_cyc, e.lat);
                    check("mem_valid_cycles", mv_cnt, e.mv);
                end
                busy = 0;
            end
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                mv_cnt  = 0;
                busy    = 1;
                if (cfg_q.size() > 0) begin
                    c = cfg_q.pop_front();
                    cur_w = c.w;
                    cur_stall = c.stall;
                end
            end
        end
    end

    task automatic predict(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int w, input bit stall);
        int          size;
        int          off;
        int          idx;
        bit          fault;
        logic [31:0] mask;
        logic [31:0] rep;
        logic [31:0] v;
        exp_t        e;
        mexp_t       m;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        fault = (size == 0) || (we && f3 >= 3'd4) || (a >= 32'h0040_0000);
        if (size != 0 && (a % size) != 0) fault = 1;
        off  = int'(a % 4);
        idx  = int'((a / 4) % 256);
        mask = (32'd1 << (8 * size)) - 32'd1;
        rep  = (size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'd1;
        e.rdata = '0;
        e.err   = 1'b0;
        if (fault) begin
            e.err = 1'b1; e.lat = 1; e.mv = 0;
        end else if (stall) begin
            e.err = 1'b1; e.lat = TO + 1; e.mv = TO;
        end else begin
            e.lat = 2 + w;
            e.mv  = w + 1;
            m.addr = 20'(a / 4);
            if (we) begin
                m.is_store = 1;
                m.wstrb = 4'(((1 << size) - 1) << off);
                m.wdata = (wd & mask) * rep;
                for (int i = 0; i < size; i++) ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
            end else begin
                m.is_store = 0;
                m.wstrb = 4'b0000;
                m.wdata = '0;
                v = (ref_mem[idx] >> (8 * off)) & mask;
                if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v - (32'd1 << (8 * size));
                e.rdata = v;
            end
            mem_q.push_back(m);
        end
        exp_q.push_back(e);
    endtask

    // Called one time unit after a rising edge; returns one time unit after the accepting edge.
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int w, input bit stall);
        int n;
        cfg_t c;
        predict(we, f3, a, wd, w, stall);
        c.w = w;
        c.stall = stall;
        cfg_q.push_back(c);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 30);
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: req_ready not seen within 30 cycles");
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid  = 1'b0;
            req_we     = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
        check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
        check({tag, "_mem_valid"}, {31'b0, mem_valid}, 32'd0);
        check({tag, "_mem_wstrb"}, {28'b0, mem_wstrb}, 32'd0);
        check({tag, "_mem_addr"}, {12'b0, mem_addr}, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        logic [2:0]  legal_f3 [5];
        logic [2:0]  bad_f3 [3];
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;
        int          n;

        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bad_f3   = '{3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[8'h40]  = 32'h80FF_7F01;
        ref_mem[8'h40] = 32'h80FF_7F01;

        #1 rst_n = 1'b0;
        #2 check_outputs_zero("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("ready_before_edge", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("ready_after_reset", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        issue(1'b0, 3'd0, 32'h0000_0101, $urandom, 0, 1'b0);
        issue(1'b0, 3'd0, 32'h0000_0103, $urandom, 0, 1'b0);
        issue(1'b0, 3'd5, 32'h0000_0102, $urandom, 0, 1'b0);
        issue(1'b0, 3'd1, 32'h0000_0102, $urandom, 0, 1'b0);
        issue(1'b1, 3'd0, 32'h0000_0102, 32'h0000_00A5, 0, 1'b0);
        issue(1'b0, 3'd2, 32'h0000_0006, $urandom, 0, 1'b0);
        issue(1'b0, 3'd2, 32'h0040_0000, $urandom, 0, 1'b0);
        issue(1'b1, 3'd2, 32'h0000_0100, $urandom, 0, 1'b1);
        issue(1'b0, 3'd2, 32'h0000_0100, $urandom, 3, 1'b0);
        issue(1'b1, 3'd4, 32'h0000_0100, $urandom, 0, 1'b0);
        issue(1'b1, 3'd1, 32'h0000_0203, $urandom, 0, 1'b0);

        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        // Abort a stalled access with reset: nothing further may come out.
        issue(1'b0, 3'd2, 32'h0000_0200, $urandom, 0, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_valid && n < 10);
        check("abort_mem_valid_seen", {31'b0, mem_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("abort");
        exp_q.delete();
        mem_q.delete();
        cfg_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("abort_ready_before_edge", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("abort_ready_after_release", {31'b0, req_ready}, 32'd1);
        check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;

        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 19);
            f3 = (r < 17) ? legal_f3[r % 5] : bad_f3[r - 17];
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 15) == 0) a[$urandom_range(22, 31)] = 1'b1;
            issue(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 3),
                  $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses still outstanding", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, meaning the width of the memory word index.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the data word width.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the number of cycles to wait for mem_ready before flagging an error.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: core request valid.
REQ-007 SHALL have port req_ready, output, 1 bit: request accepted when req_valid and req_ready are both high.
REQ-008 SHALL have port req_we, input, 1 bit: 1 for store, 0 for load.
REQ-009 SHALL have port req_funct3, input, 3 bits: RISC-V size/sign code; 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port req_addr, input, 32 bits: byte address.
REQ-011 SHALL have port req_wdata, input, DATA_WIDTH bits: store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1 bit: one-cycle response pulse.
REQ-013 SHALL have port resp_rdata, output, DATA_WIDTH bits: extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1 bit: access fault, valid with resp_valid.
REQ-015 SHALL have port mem_valid, output, 1 bit: memory request valid.
REQ-016 SHALL have port mem_wstrb, output, 4 bits: byte write strobes; 0000 for loads.
REQ-017 SHALL have port mem_addr, output, ADDR_WIDTH bits: word index, req_addr[ADDR_WIDTH+1:2].
REQ-018 SHALL have port mem_wdata, output, DATA_WIDTH bits: lane-replicated store data.
REQ-019 SHALL have port mem_rdata, input, DATA_WIDTH bits: little-endian memory word.
REQ-020 SHALL have port mem_ready, input, 1 bit: memory completion; may be combinational from mem_valid.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 On accept, SHALL register the request; if there is no fault, go to ACCESS, else go directly to RESP with resp_err=1 and no memory access.
REQ-023 Fault conditions SHALL be: H/HU with addr[0]=1; W with addr[1:0]!=00; funct3 of 011, 110 or 111; stores with funct3[2]=1; req_addr[31:ADDR_WIDTH+2] nonzero.
REQ-024 In ACCESS, mem_valid, mem_addr, mem_wstrb and mem_wdata SHALL be driven from registers and held stable until mem_ready is sampled high.
REQ-025 Store strobes SHALL be: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111.
REQ-026 Store data SHALL be: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
REQ-027 Load data SHALL select the byte or halfword lane by addr[1:0]; B and H sign-extend; BU and HU zero-extend; W passes through.
REQ-028 mem_rdata SHALL be captured on the edge where mem_valid&&mem_ready is high; the FSM then goes to RESP and mem_valid drops the next cycle.
REQ-029 Latency with zero-wait memory SHALL be: accept at cycle 0, mem_valid in cycle 1, resp_valid in cycle 2, IDLE in cycle 3.
REQ-030 A wait counter SHALL run in ACCESS; when it reaches TIMEOUT without mem_ready, the FSM SHALL go to RESP with resp_err=1 and drop mem_valid.
REQ-031 RESP SHALL last exactly one cycle and return to IDLE; back-to-back requests SHALL therefore be spaced at least 3 cycles apart.
REQ-032 The unit SHALL ignore req_valid outside IDLE; the core holds its request until it is accepted.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE and the wait counter to 0.
REQ-034 rst_n low SHALL immediately force req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_valid=0, mem_wstrb=0, mem_addr=0 and mem_wdata=0.
REQ-035 req_ready SHALL rise the first cycle after reset deassertion.
REQ-036 Reset mid-ACCESS SHALL abort the access with no response and no further strobes.

Structure
REQ-037 riscv_pkg SHALL hold the funct3 encodings, the FSM state encoding and the strobe constants.
REQ-038 The load lane-extract/extend logic SHALL be a combinational sub-module named load_align.

Verification
REQ-039 SB addr 0x00000102, wdata 0x000000A5 -> mem_addr 0x40, mem_wstrb 0100, mem_wdata 0xA5A5A5A5, resp_err 0, resp_valid at cycle 2.
REQ-040 Memory word at 0x100 = 0x80FF7F01; LB at 0x101 -> 0x0000007F; LB at 0x103 -> 0xFFFFFF80; LHU at 0x102 -> 0x000080FF; LH at 0x102 -> 0xFFFF80FF.
REQ-041 LW at 0x00000006 -> no mem_valid, resp_valid at cycle 1 with resp_err=1 and resp_rdata=0.
REQ-042 LW at 0x00400000 (out of range for ADDR_WIDTH 20) -> resp_err=1, no memory access.
REQ-043 mem_ready held low with TIMEOUT=4 -> mem_valid high for 4 cycles, then resp_err=1 and mem_valid low.
REQ-044 rst_n pulsed low during ACCESS -> mem_valid low immediately, no resp_valid, req_ready=1 the cycle after release.
